// File: rtl/bram_access_ctrl.sv
// Request/response front end for a BRAM whose write-data word also carries the lane selects
// and a dynamic write enable; reads return in order through a credit-limited 4-entry FIFO.
module bram_access_ctrl #(
  parameter int ReadAddressMSBFromDataLSB  = 24,
  parameter int WriteAddressMSBFromDataLSB = 16,
  parameter int WriteEnableFromData        = 20,
  parameter int WidthMode                  = 2,
  parameter int OutputRegister             = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [9:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic [7:0]  bram_rd_addr,
  output logic [7:0]  bram_wr_addr,
  output logic [31:0] bram_wr_data,
  input  logic [31:0] bram_rd_data
);
  localparam int Latency = 1 + OutputRegister;

  logic [Latency-1:0] r_inflight;
  logic [15:0]        r_fifo [4];
  logic [1:0]         r_wrPtr;
  logic [1:0]         r_rdPtr;
  logic [2:0]         r_count;
  logic               r_lastWrValid;
  logic [7:0]         r_lastWrAddr;
  logic [7:0]         r_rdAddr;
  logic [7:0]         r_wrAddr;
  logic [31:0]        r_wrData;

  logic        w_hazard;
  logic        w_creditFull;
  logic        w_accept;
  logic        w_issueRead;
  logic        w_push;
  logic        w_pop;
  logic [2:0]  w_inflightCnt;
  logic [1:0]  w_lane;
  logic [15:0] w_rdData;
  logic [7:0]  w_rdAddr;
  logic [7:0]  w_wrAddr;
  logic [31:0] w_wrData;
  logic        w_unused;

  always_comb begin
    w_inflightCnt = 3'd0;
    for (int i = 0; i < Latency; i++) begin
      w_inflightCnt = w_inflightCnt + {2'b00, r_inflight[i]};
    end
  end

  // Reads in flight already own a FIFO slot, so the credit counts them with the stored entries.
  assign w_creditFull = ({1'b0, r_count} + {1'b0, w_inflightCnt}) >= 4'd4;
  assign w_hazard     = r_lastWrValid && req_valid && !req_write && (req_addr[7:0] == r_lastWrAddr);
  assign req_ready    = !rst && !w_creditFull && !w_hazard;
  assign w_accept     = req_valid && req_ready;
  assign w_issueRead  = w_accept && !req_write;

  assign w_lane   = (WidthMode == 1) ? {1'b0, req_addr[8]} : req_addr[9:8];
  assign w_rdData = (WidthMode == 1) ? bram_rd_data[15:0] : {8'h00, bram_rd_data[7:0]};
  assign w_push   = r_inflight[Latency-1];

  assign rsp_valid = !rst && (r_count != 3'd0);
  assign w_pop     = rsp_valid && rsp_ready;
  assign rsp_rdata = rsp_valid ? r_fifo[r_rdPtr] : 16'h0000;

  assign w_unused = ^{req_addr[9], req_wdata[15:8], bram_rd_data};

  // Idle cycles keep every BRAM field from the last request except the write enable.
  always_comb begin
    w_rdAddr = r_rdAddr;
    w_wrAddr = r_wrAddr;
    w_wrData = r_wrData;
    w_wrData[WriteEnableFromData] = 1'b0;
    if (w_accept && req_write) begin
      w_wrAddr = req_addr[7:0];
      w_wrData[WriteEnableFromData] = 1'b1;
      w_wrData[WriteAddressMSBFromDataLSB +: 2] = w_lane;
      if (WidthMode == 1) begin
        w_wrData[15:0] = req_wdata;
      end else begin
        w_wrData[15:0] = {8'h00, req_wdata[7:0]};
      end
    end else if (w_accept) begin
      w_rdAddr = req_addr[7:0];
      w_wrData[ReadAddressMSBFromDataLSB +: 2] = w_lane;
    end
  end

  assign bram_rd_addr = rst ? 8'h00 : w_rdAddr;
  assign bram_wr_addr = rst ? 8'h00 : w_wrAddr;
  assign bram_wr_data = rst ? 32'h0000_0000 : w_wrData;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight    <= '0;
      r_wrPtr       <= 2'd0;
      r_rdPtr       <= 2'd0;
      r_count       <= 3'd0;
      r_lastWrValid <= 1'b0;
      r_lastWrAddr  <= 8'h00;
      r_rdAddr      <= 8'h00;
      r_wrAddr      <= 8'h00;
      r_wrData      <= 32'h0000_0000;
      for (int i = 0; i < 4; i++) begin
        r_fifo[i] <= 16'h0000;
      end
    end else begin
      r_inflight[0] <= w_issueRead;
      for (int i = 1; i < Latency; i++) begin
        r_inflight[i] <= r_inflight[i-1];
      end
      if (w_push) begin
        r_fifo[r_wrPtr] <= w_rdData;
        r_wrPtr         <= r_wrPtr + 2'd1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      r_lastWrValid <= w_accept && req_write;
      if (w_accept && req_write) begin
        r_lastWrAddr <= req_addr[7:0];
      end
      r_rdAddr <= w_rdAddr;
      r_wrAddr <= w_wrAddr;
      r_wrData <= w_wrData;
    end
  end

endmodule

// File: tb/tb_bram_access_ctrl.sv
// Bench for bram_access_ctrl: three configurations (8-bit, 16-bit, 8-bit with output register),
// each with a behavioural BRAM, checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_bram_access_ctrl;
  localparam int NumDut = 3;

  typedef struct packed {
    logic [15:0] data;
    int          due;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid   [NumDut];
  logic        reqReady   [NumDut];
  logic        reqWrite   [NumDut];
  logic [9:0]  reqAddr    [NumDut];
  logic [15:0] reqWdata   [NumDut];
  logic        rspValid   [NumDut];
  logic        rspReady   [NumDut];
  logic [15:0] rspRdata   [NumDut];
  logic [7:0]  bramRdAddr [NumDut];
  logic [7:0]  bramWrAddr [NumDut];
  logic [31:0] bramWrData [NumDut];
  logic [31:0] bramRdData [NumDut];

  int compCount = 0;
  int errCount = 0;
  int cyc = 0;
  int firstValidCyc = -1;
  int lastAccCyc = 0;
  rsp_t expQ[$];
  logic        prevWrValid [NumDut] = '{default: 1'b0};
  logic [7:0]  prevWrAddr  [NumDut] = '{default: 8'h00};
  logic [15:0] refMem [NumDut][256][4] = '{default: '0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < NumDut; g++) begin : gDut
    logic [15:0] mem [256][4] = '{default: 16'h0000};
    logic [31:0] q1 = 32'h0;
    logic [31:0] q2 = 32'h0;

    bram_access_ctrl #(
      .WidthMode(g == 1 ? 1 : 2),
      .OutputRegister(g == 2 ? 1 : 0)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .req_valid(reqValid[g]),
      .req_ready(reqReady[g]),
      .req_write(reqWrite[g]),
      .req_addr(reqAddr[g]),
      .req_wdata(reqWdata[g]),
      .rsp_valid(rspValid[g]),
      .rsp_ready(rspReady[g]),
      .rsp_rdata(rspRdata[g]),
      .bram_rd_addr(bramRdAddr[g]),
      .bram_wr_addr(bramWrAddr[g]),
      .bram_wr_data(bramWrData[g]),
      .bram_rd_data(bramRdData[g])
    );

    // Synchronous BRAM: lane fields live in the write-data word, optional extra output stage.
    always @(posedge clk) begin
      q1 <= {16'h0000, mem[bramRdAddr[g]][bramWrData[g][25:24]]};
      q2 <= q1;
      if (bramWrData[g][20]) begin
        mem[bramWrAddr[g]][bramWrData[g][17:16]] <=
          (g == 1) ? bramWrData[g][15:0] : {8'h00, bramWrData[g][7:0]};
      end
    end
    assign bramRdData[g] = (g == 2) ? q2 : q1;
  end

  function automatic int latOf(input int k);
    return (k == 2) ? 2 : 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compCount++;
    assert (observed === expected) else begin
      errCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int k, input logic valid, input logic write,
                               input logic [9:0] addr, input logic [15:0] wdata, input logic rdy);
    for (int j = 0; j < NumDut; j++) begin
      reqValid[j] = 1'b0;
      reqWrite[j] = 1'b0;
      reqAddr[j]  = 10'h000;
      reqWdata[j] = 16'h0000;
      rspReady[j] = 1'b1;
    end
    reqValid[k] = valid;
    reqWrite[k] = write;
    reqAddr[k]  = addr;
    reqWdata[k] = wdata;
    rspReady[k] = rdy;
  endtask

  // One clock: sample at the falling edge, compare against the model, then advance past the rising edge.
  task automatic runCycle(input int k, output logic acc);
    logic [1:0] lane;
    logic       hazard;
    logic       expValid;
    rsp_t       r;
    acc = 1'b0;
    @(negedge clk);
    if (rspValid[k] === 1'b1 && firstValidCyc < 0) firstValidCyc = cyc;
    if (rst) begin
      checkOutput("rst_req_ready", 32'(reqReady[k]), 32'd0);
      checkOutput("rst_rsp_valid", 32'(rspValid[k]), 32'd0);
      checkOutput("rst_rsp_rdata", 32'(rspRdata[k]), 32'd0);
      checkOutput("rst_bram_we", 32'(bramWrData[k][20]), 32'd0);
      checkOutput("rst_bram_addr", {16'h0000, bramRdAddr[k], bramWrAddr[k]}, 32'd0);
      expQ.delete();
      for (int j = 0; j < NumDut; j++) prevWrValid[j] = 1'b0;
    end else begin
      lane = (k == 1) ? {1'b0, reqAddr[k][8]} : reqAddr[k][9:8];
      hazard = reqValid[k] && !reqWrite[k] && prevWrValid[k] && (reqAddr[k][7:0] == prevWrAddr[k]);
      checkOutput("req_ready", 32'(reqReady[k]), 32'((expQ.size() < 4) && !hazard));
      expValid = (expQ.size() > 0) && (expQ[0].due <= cyc);
      checkOutput("rsp_valid", 32'(rspValid[k]), 32'(expValid));
      if (expValid) checkOutput("rsp_rdata", 32'(rspRdata[k]), 32'(expQ[0].data));
      acc = reqValid[k] && reqReady[k];
      if (acc && reqWrite[k]) begin
        checkOutput("wr_addr", 32'(bramWrAddr[k]), 32'(reqAddr[k][7:0]));
        checkOutput("wr_we", 32'(bramWrData[k][20]), 32'd1);
        checkOutput("wr_lane", 32'(bramWrData[k][17:16]), 32'(lane));
        if (k == 1) begin
          checkOutput("wr_data16", 32'(bramWrData[k][15:0]), 32'(reqWdata[k]));
          refMem[k][reqAddr[k][7:0]][lane] = reqWdata[k];
        end else begin
          checkOutput("wr_data8", 32'(bramWrData[k][7:0]), 32'(reqWdata[k][7:0]));
          refMem[k][reqAddr[k][7:0]][lane] = {8'h00, reqWdata[k][7:0]};
        end
      end else if (acc) begin
        checkOutput("rd_addr", 32'(bramRdAddr[k]), 32'(reqAddr[k][7:0]));
        checkOutput("rd_lane", 32'(bramWrData[k][25:24]), 32'(lane));
        checkOutput("rd_we", 32'(bramWrData[k][20]), 32'd0);
        r.data = refMem[k][reqAddr[k][7:0]][lane];
        r.due  = cyc + latOf(k) + 1;
        expQ.push_back(r);
        lastAccCyc = cyc;
      end else begin
        checkOutput("idle_we", 32'(bramWrData[k][20]), 32'd0);
      end
      if (expValid && rspReady[k]) void'(expQ.pop_front());
      for (int j = 0; j < NumDut; j++) prevWrValid[j] = 1'b0;
      prevWrValid[k] = acc && reqWrite[k];
      if (acc && reqWrite[k]) prevWrAddr[k] = reqAddr[k][7:0];
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic issue(input int k, input logic write, input logic [9:0] addr,
                       input logic [15:0] wdata, output int waited);
    logic acc;
    acc = 1'b0;
    waited = 0;
    while (!acc && waited < 20) begin
      applyStimulus(k, 1'b1, write, addr, wdata, 1'b1);
      runCycle(k, acc);
      if (!acc) waited++;
    end
    if (!acc) begin
      compCount++;
      errCount++;
      $error("[TB] FAIL issue_timeout: observed=not accepted expected=accepted (addr %0h)", addr);
    end
  endtask

  task automatic drain(input int k);
    logic acc;
    int n;
    n = 0;
    while (expQ.size() > 0 && n < 40) begin
      applyStimulus(k, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b1);
      runCycle(k, acc);
      n++;
    end
    if (expQ.size() > 0) begin
      compCount++;
      errCount++;
      $error("[TB] FAIL drain_timeout: observed=%0d pending expected=0", expQ.size());
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(k, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b1);
      runCycle(k, acc);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic acc;
    int waited;
    int accCnt;
    int lat0;
    int lat2;

    rst = 1'b1;
    for (int k = 0; k < NumDut; k++) begin
      for (int i = 0; i < 2; i++) begin
        applyStimulus(k, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b1);
        runCycle(k, acc);
      end
    end
    rst = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b1);
    runCycle(0, acc);

    // 8-bit write/read at lane 3, word 0x10, with read latency measured from acceptance.
    issue(0, 1'b1, 10'h310, 16'h00A5, waited);
    firstValidCyc = -1;
    issue(0, 1'b0, 10'h310, 16'h0000, waited);
    drain(0);
    lat0 = firstValidCyc - lastAccCyc;
    checkOutput("latency_or0", 32'(lat0), 32'd2);

    // Read right after a write to the same word stalls exactly one cycle.
    issue(0, 1'b1, 10'h040, 16'h005A, waited);
    issue(0, 1'b0, 10'h040, 16'h0000, waited);
    checkOutput("hazard_stall", 32'(waited), 32'd1);
    drain(0);

    // 16-bit mode: two lanes of one word, read back in order.
    issue(1, 1'b1, 10'h120, 16'hBEEF, waited);
    issue(1, 1'b1, 10'h020, 16'h1234, waited);
    issue(1, 1'b0, 10'h120, 16'h0000, waited);
    issue(1, 1'b0, 10'h020, 16'h0000, waited);
    drain(1);

    // Credit limit with responses blocked, for both latencies.
    for (int k = 0; k < NumDut; k += 2) begin
      for (int n = 0; n < 4; n++) issue(k, 1'b1, {2'b00, 8'h50 + 8'(n)}, 16'(16'h11 * (n + 1)), waited);
      accCnt = 0;
      for (int n = 0; n < 6; n++) begin
        applyStimulus(k, 1'b1, 1'b0, {2'b00, 8'h50 + 8'(n)}, 16'h0000, 1'b0);
        runCycle(k, acc);
        if (acc) accCnt++;
      end
      checkOutput("credit_accepted", 32'(accCnt), 32'd4);
      applyStimulus(k, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0);
      runCycle(k, acc);
      drain(k);
    end

    // Output register adds one cycle of read latency.
    issue(2, 1'b1, 10'h177, 16'h003C, waited);
    firstValidCyc = -1;
    issue(2, 1'b0, 10'h177, 16'h0000, waited);
    drain(2);
    lat2 = firstValidCyc - lastAccCyc;
    checkOutput("latency_or1", 32'(lat2), 32'(lat0 + 1));

    // Reset with reads both in flight and queued; nothing may surface afterwards.
    for (int n = 0; n < 4; n++) begin
      applyStimulus(2, 1'b1, 1'b0, {2'b00, 8'h50 + 8'(n)}, 16'h0000, 1'b0);
      runCycle(2, acc);
    end
    rst = 1'b1;
    applyStimulus(2, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0);
    runCycle(2, acc);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(2, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b1);
      runCycle(2, acc);
    end

    // Randomized traffic on a small address window so hazards and back-pressure occur often.
    for (int k = 0; k < NumDut; k++) begin
      for (int i = 0; i < 150; i++) begin
        applyStimulus(k, ($urandom % 4) != 0, ($urandom % 2) == 1,
                      {2'($urandom), 8'h60 + 8'($urandom % 4)}, 16'($urandom),
                      ($urandom % 4) != 0);
        runCycle(k, acc);
      end
      drain(k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule
